// File: rtl/upower_pkg.sv
// Shared uPOWER definitions: opcodes, ALU op codes, FSM states, load sizes.
package upower_pkg;

    // Primary opcodes (instr[31:26]) handled by the load path
    localparam logic [5:0] OP_LD  = 6'd58;
    localparam logic [5:0] OP_LWZ = 6'd32;
    localparam logic [5:0] OP_LBZ = 6'd34;

    // ALU_64 operation select
    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;

    // Load FSM states; encoding is visible on the debug state port
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        MEM  = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Access size: doubleword, word, byte
    typedef enum logic [1:0] {
        SZ_D = 2'd0,
        SZ_W = 2'd1,
        SZ_B = 2'd2
    } size_t;

    // D-form / DS-form instruction layout
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [4:0]  ra;
        logic [15:0] d;
    } dform_t;

    // Natural-alignment check: doublewords on 8, words on 4, bytes anywhere
    function automatic logic misaligned(input size_t sz, input logic [2:0] ea_lo);
        logic r;
        case (sz)
            SZ_D:    r = (ea_lo != 3'b000);
            SZ_W:    r = (ea_lo[1:0] != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ALU_64.sv
// Small combinational ALU; the load path only uses it as the EA adder.
module ALU_64
    import upower_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [N-1:0] o_result
);

    // Operation select; add/sub wrap modulo 2^N with carry discarded
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_OP_AND: o_result = i_a & i_b;
            ALU_OP_OR:  o_result = i_a | i_b;
            ALU_OP_ADD: o_result = i_a + i_b;
            ALU_OP_SUB: o_result = i_a - i_b;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/load_align.sv
// Big-endian extraction of a doubleword, word or byte from a memory doubleword,
// zero-extended to N bits. Byte k of the doubleword lives at bits [N-1-8k -: 8].
module load_align
    import upower_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] i_word,
    input  logic [2:0]   i_off,
    input  size_t        i_size,
    output logic [N-1:0] o_data
);

    logic [7:0] w_byte;

    // Byte lane select: offset 0 is the most significant byte
    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            3'd0: w_byte = i_word[N-1    -: 8];
            3'd1: w_byte = i_word[N-1-8  -: 8];
            3'd2: w_byte = i_word[N-1-16 -: 8];
            3'd3: w_byte = i_word[N-1-24 -: 8];
            3'd4: w_byte = i_word[N-1-32 -: 8];
            3'd5: w_byte = i_word[N-1-40 -: 8];
            3'd6: w_byte = i_word[N-1-48 -: 8];
            3'd7: w_byte = i_word[N-1-56 -: 8];
            default: w_byte = 8'h00;
        endcase
    end

    // Size select and zero extension; offset bit 2 picks the word half
    always_comb begin
        o_data = i_word;
        case (i_size)
            SZ_D: o_data = i_word;
            SZ_W: o_data = i_off[2] ? {{(N-32){1'b0}}, i_word[31:0]}
                                    : {{(N-32){1'b0}}, i_word[N-1 -: 32]};
            SZ_B: o_data = {{(N-8){1'b0}}, w_byte};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle uPOWER load datapath (ld / lwz / lbz).
// Flow: IDLE -accept-> ADDR (read RA, form EA, check) -> MEM (read) -> WB (write RT).
// Illegal opcode, misalignment or memory timeout go to ERR for a one-cycle err pulse.
//
// Memory handshake: mem_read is the request and is held high, with mem_addr stable,
// from the first MEM cycle until a clock edge at which mem_ready is sampled high;
// mem_rdata is taken on that same edge. mem_ready on the first MEM cycle is honoured.
// If mem_ready has not been seen after TIMEOUT MEM cycles the request is dropped.
module load_unit
    import upower_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  instruction,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [4:0]   rf_ra_addr,
    input  logic [N-1:0] rf_ra_data,
    output logic         rf_we,
    output logic [4:0]   rf_wa,
    output logic [N-1:0] rf_wd,
    output logic [N-1:0] mem_addr,
    output logic         mem_read,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic [2:0]   o_dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    dform_t        r_instr;
    logic [2:0]    r_ea_lo;
    logic [CW-1:0] r_cnt;

    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_mem_read;
    logic          r_rf_we;
    logic [4:0]    r_rf_ra_addr;
    logic [4:0]    r_rf_wa;
    logic [N-1:0]  r_rf_wd;
    logic [N-1:0]  r_mem_addr;

    size_t         w_size;
    logic          w_illegal;
    logic          w_misalign;
    logic [N-1:0]  w_disp;
    logic [N-1:0]  w_base;
    logic [N-1:0]  w_ea;
    logic [N-1:0]  w_load_data;

    // Decode captured instruction: access size, legality and sign-extended displacement
    always_comb begin
        w_size    = SZ_D;
        w_illegal = 1'b0;
        w_disp    = {{(N-16){r_instr.d[15]}}, r_instr.d};
        case (r_instr.op)
            OP_LD: begin
                // DS-form: low two bits are the extended opcode, 00 selects ld
                w_size    = SZ_D;
                w_illegal = (r_instr.d[1:0] != 2'b00);
                w_disp    = {{(N-16){r_instr.d[15]}}, r_instr.d[15:2], 2'b00};
            end
            OP_LWZ:  w_size = SZ_W;
            OP_LBZ:  w_size = SZ_B;
            default: w_illegal = 1'b1;
        endcase
    end

    // RA field of zero means literal base 0, not register 0
    assign w_base = (r_instr.ra == 5'd0) ? '0 : rf_ra_data;

    ALU_64 #(.N(N)) u_ea_adder (
        .i_a      (w_base),
        .i_b      (w_disp),
        .i_op     (ALU_OP_ADD),
        .o_result (w_ea)
    );

    assign w_misalign = misaligned(w_size, w_ea[2:0]);

    load_align #(.N(N)) u_align (
        .i_word (mem_rdata),
        .i_off  (r_ea_lo),
        .i_size (w_size),
        .o_data (w_load_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && !r_busy) begin
                    w_next = ADDR;
                end
            end
            ADDR: w_next = (w_illegal || w_misalign) ? ERR : MEM;
            MEM: begin
                if (mem_ready) begin
                    w_next = WB;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_next = ERR;
                end
            end
            WB:      w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so they align with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_read   <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_ra_addr <= '0;
            r_rf_wa      <= '0;
            r_rf_wd      <= '0;
            r_mem_addr   <= '0;
            r_instr      <= '0;
            r_ea_lo      <= '0;
            r_cnt        <= '0;
        end else begin
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == WB);
            r_rf_we    <= (w_next == WB);
            r_err      <= (w_next == ERR);
            r_mem_read <= (w_next == MEM);

            if (r_state == IDLE && w_next == ADDR) begin
                r_instr      <= instruction;
                r_rf_ra_addr <= instruction[20:16];
            end

            if (r_state == ADDR && w_next == MEM) begin
                r_ea_lo    <= w_ea[2:0];
                r_mem_addr <= {w_ea[N-1:3], 3'b000};
            end

            // Counts completed MEM cycles of the current request
            if (r_state == MEM && w_next == MEM) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == MEM && w_next == WB) begin
                r_rf_wa <= r_instr.rt;
                r_rf_wd <= w_load_data;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_read    = r_mem_read;
    assign mem_addr    = r_mem_addr;
    assign rf_we       = r_rf_we;
    assign rf_wa       = r_rf_wa;
    assign rf_wd       = r_rf_wd;
    assign rf_ra_addr  = r_rf_ra_addr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: RegFile and DataMemory models, scoreboard on RT writes / err.
module tb_load_unit;

    localparam int N   = 64;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  instruction;
    logic         busy;
    logic         done;
    logic         err;
    logic [4:0]   rf_ra_addr;
    logic [N-1:0] rf_ra_data;
    logic         rf_we;
    logic [4:0]   rf_wa;
    logic [N-1:0] rf_wd;
    logic [N-1:0] mem_addr;
    logic         mem_read;
    logic [N-1:0] mem_rdata;
    logic         mem_ready;
    logic [2:0]   dbg_state;

    logic [N-1:0] rf_model [32];
    logic [63:0]  mem_model [logic [63:0]];
    logic [69:0]  exp_q [$];

    int n_total = 0;
    int n_bad = 0;
    int mem_delay = 0;
    int mem_wait_cnt = 0;
    int mem_cycles = 0;
    logic [N-1:0] last_mem_addr = '0;

    // clock / reset
    always #5 clk = ~clk;

    load_unit #(.N(N), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rf_ra_addr  (rf_ra_addr),
        .rf_ra_data  (rf_ra_data),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .o_dbg_state (dbg_state)
    );

    assign rf_ra_data = rf_model[rf_ra_addr];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 64'h0;
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] ra, input logic [15:0] d);
        return {op, rt, ra, d};
    endfunction

    // Memory responder: ready after mem_delay waiting cycles of an outstanding request
    always @(negedge clk) begin
        if (rst && mem_read) begin
            mem_cycles    = mem_cycles + 1;
            last_mem_addr = mem_addr;
            if (mem_wait_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem_rd(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
            mem_wait_cnt++;
        end else begin
            mem_ready    = 1'b0;
            mem_wait_cnt = 0;
        end
    end

    // Scoreboard: every rf_we or err pulse consumes one expected entry {err, rt, data}
    always @(negedge clk) begin
        logic [69:0] e;
        if (rst && (rf_we || err)) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", {rf_we, err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_err", err, e[69]);
                check_eq("sb_we", rf_we, !e[69]);
                check_eq("sb_done", done, !e[69]);
                if (!e[69]) begin
                    check_eq("sb_wa", rf_wa, e[68:64]);
                    check_eq("sb_wd", rf_wd, e[63:0]);
                end
            end
        end
    end

    // Reference model of one load, from the architectural definition
    task automatic model(input logic [31:0] ins, output bit fault,
                         output logic [63:0] ea, output logic [63:0] data);
        logic [5:0]  op;
        logic [4:0]  ra;
        logic [63:0] base, disp, dw;
        logic [7:0]  b [8];
        int          oi;
        op   = ins[31:26];
        ra   = ins[20:16];
        base = (ra == 5'd0) ? 64'h0 : rf_model[ra];
        if (op == 6'd58) disp = {{48{ins[15]}}, ins[15:2], 2'b00};
        else             disp = {{48{ins[15]}}, ins[15:0]};
        ea = base + disp;
        dw = mem_rd({ea[63:3], 3'b000});
        for (int k = 0; k < 8; k++) b[k] = dw[63-8*k -: 8];
        oi = int'(ea[2:0]);
        fault = 1'b0;
        data  = 64'h0;
        case (op)
            6'd58: begin
                fault = (ins[1:0] != 2'b00) || (ea[2:0] != 3'b000);
                data  = dw;
            end
            6'd32: begin
                fault = (ea[1:0] != 2'b00);
                if (!fault) data = {32'h0, b[oi], b[oi+1], b[oi+2], b[oi+3]};
            end
            6'd34: data = {56'h0, b[oi]};
            default: fault = 1'b1;
        endcase
    endtask

    // Driver: issue one instruction, wait (bounded) for done/err, report latency
    task automatic run_load(input logic [31:0] ins, input int delay, input bit noisy,
                            output int lat);
        bit got;
        @(posedge clk); #1;
        check_eq("busy_idle", busy, 1'b0);
        mem_delay   = delay;
        mem_cycles  = 0;
        start       = 1'b1;
        instruction = ins;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            lat++;
            if (noisy) instruction = $urandom;
            else       start = 1'b0;
            if (done || err) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got) check_eq("wait_done", 1'b0, 1'b1);
    endtask

    task automatic run_case(input logic [31:0] ins, input int delay, input bit noisy,
                            input bit expect_tmo);
        bit          fault;
        logic [63:0] ea, data;
        int          lat, exp_lat;
        model(ins, fault, ea, data);
        if (expect_tmo) fault = 1'b1;
        exp_q.push_back({fault, ins[25:21], fault ? 64'h0 : data});
        run_load(ins, delay, noisy, lat);
        if (expect_tmo) begin
            exp_lat = 3 + TMO;
            check_eq("tmo_mem_cycles", mem_cycles, TMO);
        end else if (fault) begin
            exp_lat = 3;
            check_eq("fault_no_mem", mem_cycles, 0);
        end else begin
            exp_lat = 4 + delay;
            check_eq("mem_addr", last_mem_addr, {ea[63:3], 3'b000});
            check_eq("mem_cycles", mem_cycles, delay + 1);
        end
        check_eq("latency", lat, exp_lat);
        check_eq("busy_at_end", busy, 1'b1);
        if (!fault) rf_model[ins[25:21]] = data;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_err"}, err, 1'b0);
        check_eq({tag, "_we"}, rf_we, 1'b0);
        check_eq({tag, "_rd"}, mem_read, 1'b0);
        check_eq({tag, "_maddr"}, mem_addr, 64'h0);
        check_eq({tag, "_wa"}, rf_wa, 5'd0);
        check_eq({tag, "_wd"}, rf_wd, 64'h0);
        check_eq({tag, "_ra"}, rf_ra_addr, 5'd0);
        check_eq({tag, "_state"}, dbg_state, 3'd0);
    endtask

    initial begin
        bit found;
        rst         = 1'b0;
        start       = 1'b0;
        instruction = 32'h0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        for (int i = 0; i < 32; i++) rf_model[i] = 64'h0;
        rf_model[0] = 64'hDEAD_BEEF_0000_0000;
        rf_model[2] = 64'h20;
        rf_model[4] = 64'h10;
        mem_model[64'h00] = 64'hAABBCCDD_11223344;
        mem_model[64'h10] = 64'h0F0E0D0C_0B0A0908;
        mem_model[64'h18] = 64'h11223344_55667788;
        mem_model[64'h20] = 64'h01020304_05060708;
        for (int a = 0; a < 40; a++) mem_model[64'h100 + 64'(8*a)] = {$urandom, $urandom};
        for (int r = 8; r < 12; r++) rf_model[r] = 64'h100 + 64'(8 * $urandom_range(0, 8));

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b1;

        run_case(enc(6'd58, 5'd5, 5'd4, 16'h0008), 0, 1'b0, 1'b0);  // ld R5,8(R4)
        run_case(enc(6'd32, 5'd6, 5'd0, 16'h0004), 0, 1'b0, 1'b0);  // lwz R6,4(R0)
        run_case(enc(6'd34, 5'd7, 5'd2, 16'h0003), 0, 1'b0, 1'b0);  // lbz R7,3(R2)
        run_case(enc(6'd58, 5'd1, 5'd4, 16'h0004), 0, 1'b0, 1'b0);  // ld EA=0x14 -> err
        run_case(enc(6'd32, 5'd8, 5'd4, 16'h0002), 0, 1'b0, 1'b0);  // lwz EA=0x12 -> err
        run_case(enc(6'd31, 5'd8, 5'd4, 16'h0000), 0, 1'b0, 1'b0);  // illegal opcode
        run_case(enc(6'd58, 5'd9, 5'd4, 16'h0009), 0, 1'b0, 1'b0);  // ld with XO!=0 -> err
        run_case(enc(6'd34, 5'd9, 5'd2, 16'hFFFF), 1, 1'b0, 1'b0);  // lbz R9,-1(R2)
        run_case(enc(6'd32, 5'd10, 5'd4, 16'h0008), 2, 1'b0, 1'b0); // lwz high half
        run_case(enc(6'd58, 5'd4, 5'd4, 16'h0008), 3, 1'b1, 1'b0);  // RT==RA, start held
        run_case(enc(6'd34, 5'd11, 5'd4, 16'hFFF4), 0, 1'b0, 1'b0); // lbz from new R4

        // memory never answers
        run_case(enc(6'd58, 5'd12, 5'd2, 16'h0000), 1000, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_eq("tmo_busy_drop", busy, 1'b0);
        check_eq("tmo_idle", dbg_state, 3'd0);

        // reset while a request is outstanding
        mem_delay   = 1000;
        mem_cycles  = 0;
        start       = 1'b1;
        instruction = enc(6'd58, 5'd13, 5'd2, 16'h0000);
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_read) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_reached_mem", found, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_quiet("midrst");
        rst = 1'b1;
        run_case(enc(6'd34, 5'd14, 5'd2, 16'h0007), 0, 1'b0, 1'b0);

        // random aligned loads from the 0x100 region
        for (int i = 0; i < 12; i++) begin
            int          sel;
            logic [4:0]  ra, rt;
            logic [15:0] d;
            sel = $urandom_range(0, 2);
            ra  = 5'($urandom_range(8, 11));
            rt  = 5'($urandom_range(16, 31));
            case (sel)
                0:       d = 16'($urandom_range(0, 15) * 8);
                1:       d = 16'($urandom_range(0, 31) * 4);
                default: d = 16'($urandom_range(0, 120));
            endcase
            run_case(enc(sel == 0 ? 6'd58 : (sel == 1 ? 6'd32 : 6'd34), rt, ra, d),
                     $urandom_range(0, 3), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
